ex_wb: RTL and testbench
========================

Name: ex_wb

Overview:
- Execute/write-back stage that sits directly downstream of the instruction decoder.
- Consumes the decoded fields oper1, oper2, dest and alu_sig each cycle.
- Reads both operands from an internal register memory, performs the ALU operation, and writes the result back to dest.
- Two-stage pipeline (operand fetch -> ALU/write-back) with full forwarding; no stalls are ever required.

Parameters:
- WORD_SIZE, 32, data word width in bits.
- MEM_SIZE, 32, number of register-memory words.
- ADDR_LEN, 5, register address width; MEM_SIZE = 2**ADDR_LEN.
- CNT_LEN, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  single system clock, all state on rising edge.
- rstn  input  1  asynchronous active-low reset.
- in_valid  input  1  decoded instruction present this cycle.
- oper1  input  ADDR_LEN  source register A address.
- oper2  input  ADDR_LEN  source register B address.
- dest  input  ADDR_LEN  destination register address.
- alu_sig  input  2  ALU opcode.
- result  output  WORD_SIZE  registered ALU result of the retired instruction.
- result_dest  output  ADDR_LEN  destination of the retired instruction.
- result_valid  output  1  one-cycle pulse: result/result_dest are valid.
- overflow  output  1  signed overflow of the retired add/sub; 0 for logic ops.
- retired_count  output  CNT_LEN  number of instructions written back since reset.
- dbg_addr  input  ADDR_LEN  debug read address.
- dbg_data  output  WORD_SIZE  combinational read of mem[dbg_addr] (post-write state, no forwarding).

Behaviour:
- Reset (rstn low, asynchronous):
  - mem[i] = i for every i; EX-register valid = 0.
  - result = 0, result_dest = 0, result_valid = 0, overflow = 0, retired_count = 0.
  - Any instruction in flight is dropped and is not written back.
  - After rstn rises, the first rising edge behaves as a normal cycle.
- Stage 1, edge T (in_valid = 1):
  - Capture A = fwd(oper1), B = fwd(oper2), plus alu_sig and dest into the EX register; set ex_valid = 1.
  - When in_valid = 0, set ex_valid = 0; the other EX fields are don't-care.
- Forwarding:
  - fwd(x) = ALU result of the EX-register instruction when ex_valid = 1 and ex_dest == x.
  - Otherwise fwd(x) = mem[x].
  - Required because the write-back and the next operand capture occur on the same edge.
- Stage 2, edge T+1 (ex_valid = 1):
  - mem[ex_dest] <= alu_out; result <= alu_out; result_dest <= ex_dest.
  - result_valid <= 1; overflow <= ovf; retired_count <= retired_count + 1.
  - When ex_valid = 0: result_valid <= 0 and all other outputs hold.
- Latency: result visible 2 edges after the input is presented. Throughput: 1 instruction per cycle.
- ALU, all arithmetic modulo 2^WORD_SIZE:
  - 00: A + B.
  - 01: A - B.
  - 10: A & B.
  - 11: A ^ B.
- ovf:
  - add: A[msb] == B[msb] and sum[msb] != A[msb].
  - sub: A[msb] != B[msb] and diff[msb] != A[msb].
  - logic ops: 0.
- Register 0 is an ordinary, writable register.
- oper1 == oper2 is legal; both operands get the same (forwarded) value.
- retired_count wraps from 2^CNT_LEN-1 to 0 silently.
- Two consecutive writes to the same dest: the later one wins; forwarding always uses the youngest in-flight value.
- dbg_data reflects a write on the edge that performs it (visible the following cycle).

Test Plan:
- Reset, then dbg_addr sweep 0..31 -> dbg_data == addr; all outputs 0; retired_count = 0.
- Add, in_valid 1 cycle, oper1=3, oper2=4, dest=10, alu_sig=00 -> 2 edges later: result=7, result_dest=10, result_valid pulses 1 cycle, overflow=0; then dbg_data[10]=7, retired_count=1.
- Back-to-back hazard:
  - Instruction 1: oper1=1, oper2=2, dest=5, alu_sig=00.
  - Instruction 2, next cycle: oper1=5, oper2=5, dest=6, alu_sig=01.
  - Required response: results 3 then 0; mem[6]=0; forwarded value used, not the stale mem[5]=5.
- Overflow:
  - Preload mem[7]=0x7FFFFFFF via ops (e.g. chained adds/xors).
  - Add with mem[1]=1 -> result=0x80000000, overflow=1.
  - Then xor of the same operands -> overflow=0.
- Reset mid-operation: assert rstn low between capture and write-back -> no result_valid pulse, mem[dest] keeps its reset value, retired_count=0.
- Streaming: 40 consecutive valid adds with one bubble (in_valid=0) -> exactly one result_valid low cycle; retired_count=40; results match a reference model.

Source files
------------

// File: rtl/ex_wb.sv
// rtl/ex_wb.sv - two-stage execute/write-back stage with register memory and full forwarding
module ex_wb #(
   parameter int WORD_SIZE = 32,
   parameter int MEM_SIZE  = 32,
   parameter int ADDR_LEN  = 5,
   parameter int CNT_LEN   = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 in_valid,
   input  logic [ADDR_LEN-1:0]  oper1,
   input  logic [ADDR_LEN-1:0]  oper2,
   input  logic [ADDR_LEN-1:0]  dest,
   input  logic [1:0]           alu_sig,
   output logic [WORD_SIZE-1:0] result,
   output logic [ADDR_LEN-1:0]  result_dest,
   output logic                 result_valid,
   output logic                 overflow,
   output logic [CNT_LEN-1:0]   retired_count,
   input  logic [ADDR_LEN-1:0]  dbg_addr,
   output logic [WORD_SIZE-1:0] dbg_data
);

   localparam int MSB = WORD_SIZE - 1;

   logic [WORD_SIZE-1:0] mem [MEM_SIZE];

   logic                 ex_valid;
   logic [WORD_SIZE-1:0] ex_a;
   logic [WORD_SIZE-1:0] ex_b;
   logic [1:0]           ex_alu;
   logic [ADDR_LEN-1:0]  ex_dest;

   logic [WORD_SIZE-1:0] sum;
   logic [WORD_SIZE-1:0] diff;
   logic [WORD_SIZE-1:0] alu_out;
   logic                 ovf;
   logic [WORD_SIZE-1:0] fwd_a;
   logic [WORD_SIZE-1:0] fwd_b;

   assign sum  = ex_a + ex_b;
   assign diff = ex_a - ex_b;

   always_comb begin
      alu_out = '0;
      ovf     = 1'b0;
      unique case (ex_alu)
         2'b00: begin
            alu_out = sum;
            ovf     = (ex_a[MSB] == ex_b[MSB]) && (sum[MSB] != ex_a[MSB]);
         end
         2'b01: begin
            alu_out = diff;
            ovf     = (ex_a[MSB] != ex_b[MSB]) && (diff[MSB] != ex_a[MSB]);
         end
         2'b10: alu_out = ex_a & ex_b;
         2'b11: alu_out = ex_a ^ ex_b;
      endcase
   end

   // The in-flight result is written on the same edge that captures new operands,
   // so operands naming ex_dest must take the ALU output instead of the stale word.
   always_comb begin
      fwd_a = mem[oper1];
      fwd_b = mem[oper2];
      if (ex_valid && (ex_dest == oper1)) fwd_a = alu_out;
      if (ex_valid && (ex_dest == oper2)) fwd_b = alu_out;
   end

   assign dbg_data = mem[dbg_addr];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < MEM_SIZE; i++) mem[i] <= WORD_SIZE'(i);
         ex_valid      <= 1'b0;
         ex_a          <= '0;
         ex_b          <= '0;
         ex_alu        <= 2'b00;
         ex_dest       <= '0;
         result        <= '0;
         result_dest   <= '0;
         result_valid  <= 1'b0;
         overflow      <= 1'b0;
         retired_count <= '0;
      end else begin
         ex_valid <= in_valid;
         if (in_valid) begin
            ex_a    <= fwd_a;
            ex_b    <= fwd_b;
            ex_alu  <= alu_sig;
            ex_dest <= dest;
         end
         if (ex_valid) begin
            mem[ex_dest]  <= alu_out;
            result        <= alu_out;
            result_dest   <= ex_dest;
            result_valid  <= 1'b1;
            overflow      <= ovf;
            retired_count <= retired_count + 1'b1;
         end else begin
            result_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ex_wb.sv
// tb/tb_ex_wb.sv - directed table-driven bench for ex_wb
module tb_ex_wb;

   logic        clk;
   logic        rstn;
   logic        in_valid;
   logic [4:0]  oper1;
   logic [4:0]  oper2;
   logic [4:0]  dest;
   logic [1:0]  alu_sig;
   logic [31:0] result;
   logic [4:0]  result_dest;
   logic        result_valid;
   logic        overflow;
   logic [15:0] retired_count;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   ex_wb #(.WORD_SIZE(32), .MEM_SIZE(32), .ADDR_LEN(5), .CNT_LEN(16)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .oper1(oper1), .oper2(oper2),
      .dest(dest), .alu_sig(alu_sig), .result(result), .result_dest(result_dest),
      .result_valid(result_valid), .overflow(overflow), .retired_count(retired_count),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  o1;
      logic [4:0]  o2;
      logic [4:0]  d;
      logic [1:0]  op;
      logic [31:0] res;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  d;
   } exp_t;

   vec_t        tbl [13];
   int          n_chk;
   int          n_fail;
   int          exp_cnt;
   logic [31:0] ref_mem [32];
   exp_t        expq [$];
   logic        hist [43];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d, input logic [1:0] op);
      in_valid = v;
      oper1    = a;
      oper2    = b;
      dest     = d;
      alu_sig  = op;
   endtask

   task automatic do_reset();
      rstn     = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      exp_cnt = 0;
   endtask

   task automatic run_vec(input int i);
      drive(1'b1, tbl[i].o1, tbl[i].o2, tbl[i].d, tbl[i].op);
      step();
      chk($sformatf("v%0d_not_early", i), 32'(result_valid), 32'd0);
      in_valid = 1'b0;
      step();
      exp_cnt++;
      chk($sformatf("v%0d_valid", i), 32'(result_valid), 32'd1);
      chk($sformatf("v%0d_result", i), result, tbl[i].res);
      chk($sformatf("v%0d_dest", i), 32'(result_dest), 32'(tbl[i].d));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
      chk($sformatf("v%0d_count", i), 32'(retired_count), 32'(exp_cnt));
      dbg_addr = tbl[i].d;
      #1;
      chk($sformatf("v%0d_mem", i), dbg_data, tbl[i].res);
      step();
      chk($sformatf("v%0d_pulse_end", i), 32'(result_valid), 32'd0);
   endtask

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      exp_cnt = 0;
      dbg_addr = 5'd0;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 2'b00);

      // hand-computed from reset contents mem[i] = i
      tbl[0]  = '{5'd3,  5'd4,  5'd10, 2'b00, 32'd7,        1'b0};
      tbl[1]  = '{5'd2,  5'd9,  5'd11, 2'b01, 32'hFFFFFFF9, 1'b0};
      tbl[2]  = '{5'd10, 5'd11, 5'd12, 2'b10, 32'd1,        1'b0};
      tbl[3]  = '{5'd10, 5'd13, 5'd0,  2'b11, 32'd10,       1'b0};
      tbl[4]  = '{5'd0,  5'd0,  5'd14, 2'b00, 32'd20,       1'b0};
      tbl[5]  = '{5'd1,  5'd2,  5'd16, 2'b01, 32'hFFFFFFFF, 1'b0};
      tbl[6]  = '{5'd1,  5'd1,  5'd17, 2'b10, 32'd1,        1'b0};
      // after r17 has been doubled up to 0x80000000
      tbl[7]  = '{5'd16, 5'd17, 5'd7,  2'b11, 32'h7FFFFFFF, 1'b0};
      tbl[8]  = '{5'd7,  5'd1,  5'd19, 2'b00, 32'h80000000, 1'b1};
      tbl[9]  = '{5'd7,  5'd1,  5'd20, 2'b11, 32'h7FFFFFFE, 1'b0};
      tbl[10] = '{5'd17, 5'd1,  5'd18, 2'b01, 32'h7FFFFFFF, 1'b1};
      tbl[11] = '{5'd7,  5'd16, 5'd21, 2'b01, 32'h80000000, 1'b1};
      tbl[12] = '{5'd16, 5'd16, 5'd22, 2'b00, 32'hFFFFFFFE, 1'b0};

      do_reset();
      #1;
      for (int a = 0; a < 32; a++) begin
         dbg_addr = 5'(a);
         #1;
         chk($sformatf("reset_mem%0d", a), dbg_data, 32'(a));
      end
      chk("reset_result", result, 32'd0);
      chk("reset_dest", 32'(result_dest), 32'd0);
      chk("reset_valid", 32'(result_valid), 32'd0);
      chk("reset_ovf", 32'(overflow), 32'd0);
      chk("reset_count", 32'(retired_count), 32'd0);

      for (int i = 0; i < 7; i++) run_vec(i);

      // 31 back-to-back self-doublings of r17, each forwarded from the previous
      for (int k = 0; k < 31; k++) begin
         drive(1'b1, 5'd17, 5'd17, 5'd17, 2'b00);
         step();
      end
      in_valid = 1'b0;
      step();
      exp_cnt += 31;
      chk("dbl_result", result, 32'h80000000);
      chk("dbl_ovf", 32'(overflow), 32'd1);
      chk("dbl_count", 32'(retired_count), 32'(exp_cnt));
      step();

      for (int i = 7; i < 13; i++) run_vec(i);

      // reset between capture and write-back drops the instruction
      drive(1'b1, 5'd3, 5'd4, 5'd10, 2'b00);
      step();
      in_valid = 1'b0;
      #2;
      rstn = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_valid", 32'(result_valid), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      step();
      chk("midrst_valid_after", 32'(result_valid), 32'd0);
      chk("midrst_count", 32'(retired_count), 32'd0);
      dbg_addr = 5'd10;
      #1;
      chk("midrst_mem10", dbg_data, 32'd10);

      // back-to-back hazard: r6 = r5 - r5 where r5 is still in flight
      drive(1'b1, 5'd1, 5'd2, 5'd5, 2'b00);
      step();
      drive(1'b1, 5'd5, 5'd5, 5'd6, 2'b01);
      step();
      chk("haz1_valid", 32'(result_valid), 32'd1);
      chk("haz1_result", result, 32'd3);
      chk("haz1_dest", 32'(result_dest), 32'd5);
      in_valid = 1'b0;
      step();
      chk("haz2_valid", 32'(result_valid), 32'd1);
      chk("haz2_result", result, 32'd0);
      chk("haz2_dest", 32'(result_dest), 32'd6);
      dbg_addr = 5'd6;
      #1;
      chk("haz_mem6", dbg_data, 32'd0);
      dbg_addr = 5'd5;
      #1;
      chk("haz_mem5", dbg_data, 32'd3);
      chk("haz_count", 32'(retired_count), 32'd2);

      // streaming: 40 adds with one bubble against a sequential reference model
      do_reset();
      for (int a = 0; a < 32; a++) ref_mem[a] = 32'(a);
      begin
         int k;
         int pulses;
         int first;
         int last;
         int gaps;
         k = 0;
         pulses = 0;
         first = -1;
         last = -1;
         gaps = 0;
         for (int c = 0; c < 43; c++) begin
            if (c == 20 || c >= 41) begin
               in_valid = 1'b0;
            end else begin
               logic [4:0] a;
               logic [4:0] b;
               logic [4:0] d;
               exp_t e;
               a = 5'(k * 7 + 1);
               b = 5'(k * 3 + 2);
               d = 5'(k * 5);
               drive(1'b1, a, b, d, 2'b00);
               e.res = ref_mem[a] + ref_mem[b];
               e.d   = d;
               ref_mem[d] = e.res;
               expq.push_back(e);
               k++;
            end
            step();
            hist[c] = result_valid;
            if (result_valid) begin
               pulses++;
               if (first < 0) first = c;
               last = c;
               if (expq.size() == 0) begin
                  chk($sformatf("stream_extra_c%0d", c), 32'd1, 32'd0);
               end else begin
                  exp_t e;
                  e = expq.pop_front();
                  chk($sformatf("stream_res_c%0d", c), result, e.res);
                  chk($sformatf("stream_dest_c%0d", c), 32'(result_dest), 32'(e.d));
               end
            end
         end
         for (int c = 0; c < 43; c++)
            if (first >= 0 && c > first && c < last && !hist[c]) gaps++;
         chk("stream_pulses", 32'(pulses), 32'd40);
         chk("stream_gaps", 32'(gaps), 32'd1);
         chk("stream_leftover", 32'(expq.size()), 32'd0);
         chk("stream_count", 32'(retired_count), 32'd40);
         for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1;
            chk($sformatf("stream_mem%0d", a), dbg_data, ref_mem[a]);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
